ps2_scancode_ctrl: RTL
======================

# ps2_scancode_ctrl

Scan-code sequencer between the PS/2 byte decoder and the keyboard consumer logic. It takes the decoder's byte stream (one-cycle `valid` strobes), resolves Set-2 prefix sequences (`E0` extended, `F0` break, `E1` pause) into single key events, and buffers those events in a small FIFO. The FIFO has a valid/ready handshake, so downstream logic can stall without losing keystrokes.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: event FIFO entries. Power of two, ≥2.
- `TIMEOUT_CYCLES`, default 500000: idle clocks after which a partial prefix sequence is abandoned (10 ms at 50 MHz).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `byte_data` in 8: scan-code byte from decoder.
- `byte_valid` in 1: one-cycle strobe; `byte_data` valid this cycle.
- `ev_code` out 8: key code (final non-prefix byte).
- `ev_ext` out 1: event was `E0`-prefixed.
- `ev_break` out 1: key release (`F0` seen).
- `ev_valid` out 1: FIFO head valid.
- `ev_ready` in 1: consumer accepts head when `ev_valid & ev_ready`.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `proto_err` out 1: sticky; byte `00` or `FF` was received.
- `err_clr` in 1: clears both sticky flags.

## Operation
- Sequencer FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`), PAUSE (swallowing the `E1` tail).
- In IDLE:
  - `E0` → EXT.
  - `F0` → BRK.
  - `E1` → PAUSE, with skip counter loaded to 7.
  - `00` or `FF` → set `proto_err`, stay in IDLE.
  - Any other byte → push {code, ext=0, brk=0}.
- In EXT:
  - `F0` → EXT_BRK.
  - `E0` → stay.
  - Other byte → push {code, 1, 0}, go to IDLE.
- In BRK, any byte other than `F0`/`E0` → push {code, 0, 1}, go to IDLE. `F0` → stay. `E0` → EXT_BRK.
- In EXT_BRK, any byte other than `F0`/`E0` → push {code, 1, 1}, go to IDLE. `F0`/`E0` → stay.
- In PAUSE:
  - Each byte decrements the counter.
  - When the byte that brings the counter 1→0 arrives, push {`E1`, 0, 0} and go to IDLE.
  - Exactly 8 bytes in total produce one event.
- `00`/`FF` in any non-IDLE state: set `proto_err`, go to IDLE, no push.
- Timeout: in any non-IDLE state the idle counter increments each clock without `byte_valid` and clears on every `byte_valid`. On reaching `TIMEOUT_CYCLES` the FSM goes to IDLE with no push. The counter is held at 0 in IDLE.
- FIFO is first-word-fall-through. The head drives `ev_code`/`ev_ext`/`ev_break`.
- Full FIFO:
  - Push without a pop in the same cycle → drop the new event, set `overflow`.
  - Push and pop in the same cycle → both take effect, no overflow.
- Empty FIFO: `ev_valid`=0. Head fields hold their last value (don't-care).
- `err_clr` and a new error in the same cycle: the flag is set (set wins).

## Timing
- Reset values:
  - `ev_valid`=0, `ev_code`=00, `ev_ext`=0, `ev_break`=0.
  - `overflow`=0, `proto_err`=0.
  - FSM in IDLE; FIFO empty; counters 0.
- Latency: the terminal byte sampled at edge N (`byte_valid` high in the preceding cycle) is written to the FIFO at edge N. If the FIFO was empty, `ev_valid`=1 immediately after edge N.
- Pop occurs at the edge where `ev_valid & ev_ready`. The next entry is visible immediately after that edge.
- `overflow` and `proto_err` rise after the edge that samples the offending byte.
- Reset mid-sequence: partial prefix state and all FIFO contents are discarded. The next byte is decoded from IDLE.
- Idle counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps. FIFO pointers are `$clog2(FIFO_DEPTH)+1` bits with an MSB wrap bit for full/empty.

## Structure
- Shared package `ps2_pkg` holds:
  - State enum.
  - Byte constants `PS2_EXT=8'hE0`, `PS2_BRK=8'hF0`, `PS2_PAUSE=8'hE1`, `PS2_ERR0=8'h00`, `PS2_ERR1=8'hFF`.
  - Pause tail length 7.
  - Packed event struct {code[7:0], ext, brk}.
- One sub-module, `ps2_event_fifo`: parameterised FWFT sync FIFO with push/pop/full/empty, width 10.
- The FSM and counters live in `ps2_scancode_ctrl`.

## Test plan
- Bytes `1C`; `F0 1C` with `ev_ready`=1 → events {1C,0,0} then {1C,0,1}, each `ev_valid` one cycle after the final byte.
- `E0 75`; `E0 F0 75` → events {75,1,0} and {75,1,1}. No events are emitted for the prefix bytes.
- `E1 14 77 E1 F0 14 F0 77` → exactly one event {E1,0,0}, after the 8th byte. Then `1C` → {1C,0,0}.
- `ev_ready`=0 while 5 make codes are sent with `FIFO_DEPTH`=4 → 4 events buffered, `overflow`=1, 5th code lost. Draining yields the first 4 in order. `err_clr` → `overflow`=0.
- `E0`, then `TIMEOUT_CYCLES` idle clocks, then `1C` → event {1C,0,0} (ext cleared). `F0 FF` → `proto_err`=1, no event.
- Reset asserted after `E0 F0` with 2 events queued → `ev_valid`=0. Next `1C` → {1C,0,0}.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer.
//   - ps2_state_e : prefix-resolution FSM states
//   - byte constants for the Set-2 prefix and error codes
//   - ps2_event_t : one resolved key event {code, ext, brk}
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  // Bytes that follow the leading E1 of the Pause sequence.
  localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

  // 00 (buffer overrun) and FF (key detection error) are never key codes.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through synchronous FIFO for resolved key events.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   push, wdata  : write request and data (ignored when full unless popping)
//   pop          : consume the head (ignored when empty)
//   rdata        : current head entry, valid whenever !empty
//   full, empty  : occupancy status
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // NOTE: the storage is only a handful of entries, so it is cleared on
      // reset to give the head fields a defined 00 value straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block samples the pre-edge values regardless of statement order.
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// PS/2 Set-2 scan-code sequencer.
// Turns the decoder's byte stream into single key events by resolving the
// E0 (extended), F0 (break) and E1 (pause) prefixes, then queues the events
// in a FWFT FIFO with a valid/ready handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   byte_data/byte_valid: one-cycle byte strobe from the PS/2 decoder
//   ev_code/ev_ext/ev_break/ev_valid : FIFO head event
//   ev_ready            : consumer pops the head when ev_valid & ev_ready
//   overflow            : sticky, an event was dropped on a full FIFO
//   proto_err           : sticky, byte 00 or FF was received
//   err_clr             : clears both sticky flags (a same-cycle set wins)
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow,
  output logic       proto_err,
  input  logic       err_clr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [CW-1:0] idle_cnt;

  logic       push;
  ps2_event_t push_ev;
  ps2_event_t head_ev;
  logic       perr_set;
  logic       ovf_set;
  logic       timeout_hit;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;

  // Fires on the idle clock that brings the counter to TIMEOUT_CYCLES, so
  // a byte arriving right after exactly TIMEOUT_CYCLES idle clocks is
  // already decoded from IDLE.
  assign timeout_hit = (state_q != ST_IDLE) && (idle_cnt == TO_LAST);

  // ---------------------------------------------------------------------
  // Sequencer next-state / push decode
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d  = state_q;
    skip_d   = skip_q;
    push     = 1'b0;
    push_ev  = '{code: byte_data, ext: 1'b0, brk: 1'b0};
    perr_set = 1'b0;

    if (byte_valid) begin
      if (is_err_byte(byte_data)) begin
        perr_set = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (byte_data == PS2_EXT) begin
              state_d = ST_EXT;
            end else if (byte_data == PS2_BRK) begin
              state_d = ST_BRK;
            end else if (byte_data == PS2_PAUSE) begin
              state_d = ST_PAUSE;
              skip_d  = PS2_PAUSE_TAIL;
            end else begin
              push = 1'b1;
            end
          end

          ST_EXT: begin
            if (byte_data == PS2_BRK) begin
              state_d = ST_EXT_BRK;
            end else if (byte_data != PS2_EXT) begin
              push        = 1'b1;
              push_ev.ext = 1'b1;
              state_d     = ST_IDLE;
            end
          end

          ST_BRK: begin
            if (byte_data == PS2_EXT) begin
              state_d = ST_EXT_BRK;
            end else if (byte_data != PS2_BRK) begin
              push        = 1'b1;
              push_ev.brk = 1'b1;
              state_d     = ST_IDLE;
            end
          end

          ST_EXT_BRK: begin
            if (byte_data != PS2_BRK && byte_data != PS2_EXT) begin
              push        = 1'b1;
              push_ev.ext = 1'b1;
              push_ev.brk = 1'b1;
              state_d     = ST_IDLE;
            end
          end

          ST_PAUSE: begin
            // Tail bytes are swallowed whatever their value; the last one
            // emits a single Pause event carrying the E1 code.
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              push         = 1'b1;
              push_ev.code = PS2_PAUSE;
              state_d      = ST_IDLE;
            end
          end

          default: state_d = ST_IDLE;
        endcase
      end
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // ---------------------------------------------------------------------
  // Inter-byte idle counter: runs only while a prefix is pending
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state_d == ST_IDLE || byte_valid) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_MAX) begin
      idle_cnt <= idle_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO and handshake
  // ---------------------------------------------------------------------
  assign ev_valid = !fifo_empty;
  assign pop      = ev_valid && ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign ovf_set  = push && fifo_full && !pop;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_ev),
    .pop   (pop),
    .rdata (head_ev),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;

  // ---------------------------------------------------------------------
  // Sticky error flags: a new error outranks a simultaneous clear
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (perr_set) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule
